seven_seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment driver: N_GROUPS independent right-aligned fields of GROUP_DIGITS digits each.

---
 rtl/seven_seg_pkg.sv | 58 +++++
 rtl/seven_seg_scan_ctrl_if.sv | 26 ++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/seven_seg_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - glyph constants, converter state encoding and nibble decoder
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_NEXT,
        ST_DONE
    } conv_state_e;

    typedef struct packed {
        logic       dash;
        logic [3:0] nib;
    } digit_t;

    function automatic logic [6:0] nib_to_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - value source side of the scan controller
interface seven_seg_scan_ctrl_if #(
    parameter int N_GROUPS     = 2,
    parameter int GROUP_DIGITS = 4,
    parameter int GRP_W        = 16
);
    localparam int N_DIGITS = N_GROUPS * GROUP_DIGITS;

    logic [N_GROUPS*GRP_W-1:0] value_bus;
    logic [N_GROUPS-1:0]       hex_mode;
    logic [N_GROUPS-1:0]       blank_lz;
    logic [N_DIGITS-1:0]       dp_mask;
    logic [N_DIGITS-1:0]       blink_mask;
    logic                      conv_busy;
    logic [N_GROUPS-1:0]       overflow;

    modport master (
        output value_bus, hex_mode, blank_lz, dp_mask, blink_mask,
        input  conv_busy, overflow
    );

    modport slave (
        input  value_bus, hex_mode, blank_lz, dp_mask, blink_mask,
        output conv_busy, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one bit per cycle
module bin2bcd_seq #(
    parameter int BIN_W      = 16,
    parameter int BCD_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start) begin
            bin_d = bin_in;
            bcd_d = '0;
            cnt_d = CNT_W'(BIN_W);
        end else if (cnt_q != '0) begin
            bcd_d = {adj[4*BCD_DIGITS-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // High during the final shift; bcd holds the result from the next cycle on
    assign done = (cnt_q == CNT_W'(1)) && !start;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed 7-segment driver with time-shared BCD conversion
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_GROUPS     = 2,
    parameter int GROUP_DIGITS = 4,
    parameter int GRP_W        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                             clk_tube,
    input  logic                             rst_n,
    seven_seg_scan_ctrl_if.slave             bus,
    output logic [6:0]                       seg_tube,
    output logic                             seg_dp,
    output logic [N_GROUPS*GROUP_DIGITS-1:0] seg_enable
);
    localparam int N_DIGITS   = N_GROUPS * GROUP_DIGITS;
    localparam int BCD_DIGITS = (GRP_W + 2) / 3;
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int GRP_IW     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int BLK_W      = $clog2(2 * BLINK_FRAMES);

    conv_state_e                 state_q, state_d;
    logic [GRP_IW-1:0]           grp_q, grp_d;
    logic [GRP_W-1:0]            snap_q, snap_d;
    logic                        hex_q, hex_d;
    digit_t [N_DIGITS-1:0]       shadow_q, shadow_d;
    digit_t [N_DIGITS-1:0]       disp_q, disp_d;
    logic [N_GROUPS-1:0]         ovf_sh_q, ovf_sh_d;
    logic [N_GROUPS-1:0]         ovf_q, ovf_d;
    logic                        conv_busy_q, conv_busy_d;
    logic [IDX_W-1:0]            scan_q, scan_d;
    logic [BLK_W-1:0]            blink_q, blink_d;
    logic [6:0]                  tube_q, tube_d;
    logic                        dp_q, dp_d;
    logic [N_DIGITS-1:0]         en_q, en_d;

    logic                        frame_end;
    logic [GRP_W-1:0]            field_in;
    logic                        bcd_start, bcd_done;
    logic [4*BCD_DIGITS-1:0]     bcd;
    logic                        field_ovf;
    logic [N_DIGITS-1:0]         blank_vec;
    logic                        lz_run;
    digit_t                      cur;

    assign frame_end = (scan_q == IDX_W'(N_DIGITS - 1));
    assign field_in  = bus.value_bus[int'(grp_q)*GRP_W +: GRP_W];
    assign field_ovf = |bcd[4*BCD_DIGITS-1:4*GROUP_DIGITS];

    bin2bcd_seq #(
        .BIN_W      (GRP_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk    (clk_tube),
        .rst_n  (rst_n),
        .start  (bcd_start),
        .bin_in (field_in),
        .done   (bcd_done),
        .bcd    (bcd)
    );

    always_ff @(posedge clk_tube or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grp_q       <= '0;
            snap_q      <= '0;
            hex_q       <= 1'b0;
            shadow_q    <= '0;
            disp_q      <= '0;
            ovf_sh_q    <= '0;
            ovf_q       <= '0;
            conv_busy_q <= 1'b0;
            scan_q      <= '0;
            blink_q     <= '0;
            tube_q      <= GLYPH_BLANK;
            dp_q        <= 1'b1;
            en_q        <= '1;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            snap_q      <= snap_d;
            hex_q       <= hex_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            ovf_sh_q    <= ovf_sh_d;
            ovf_q       <= ovf_d;
            conv_busy_q <= conv_busy_d;
            scan_q      <= scan_d;
            blink_q     <= blink_d;
            tube_q      <= tube_d;
            dp_q        <= dp_d;
            en_q        <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_LOAD;
            ST_LOAD:  state_d = bus.hex_mode[grp_q] ? ST_NEXT : ST_SHIFT;
            ST_SHIFT: if (bcd_done) state_d = ST_NEXT;
            ST_NEXT:  state_d = (int'(grp_q) == N_GROUPS - 1) ? ST_DONE : ST_LOAD;
            ST_DONE:  if (frame_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grp_d       = grp_q;
        snap_d      = snap_q;
        hex_d       = hex_q;
        shadow_d    = shadow_q;
        ovf_sh_d    = ovf_sh_q;
        disp_d      = disp_q;
        ovf_d       = ovf_q;
        conv_busy_d = conv_busy_q;
        bcd_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                conv_busy_d = 1'b1;
                grp_d       = '0;
            end
            ST_LOAD: begin
                snap_d    = field_in;
                hex_d     = bus.hex_mode[grp_q];
                bcd_start = !bus.hex_mode[grp_q];
            end
            ST_NEXT: begin
                for (int p = 0; p < GROUP_DIGITS; p++) begin
                    shadow_d[int'(grp_q)*GROUP_DIGITS + p].dash = !hex_q && field_ovf;
                    shadow_d[int'(grp_q)*GROUP_DIGITS + p].nib  =
                        hex_q ? snap_q[4*p +: 4] : bcd[4*p +: 4];
                end
                ovf_sh_d[grp_q] = !hex_q && field_ovf;
                grp_d           = grp_q + GRP_IW'(1);
            end
            ST_DONE: begin
                // Commit only on a frame boundary so a frame never mixes old and new digits
                if (frame_end) begin
                    disp_d      = shadow_q;
                    ovf_d       = ovf_sh_q;
                    conv_busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        scan_d  = frame_end ? '0 : scan_q + IDX_W'(1);
        blink_d = blink_q;
        if (frame_end) begin
            blink_d = (blink_q == BLK_W'(2*BLINK_FRAMES - 1)) ? '0 : blink_q + BLK_W'(1);
        end

        // Walk each field from its leftmost digit; the rightmost digit is never blanked
        blank_vec = '0;
        lz_run    = 1'b0;
        for (int g = 0; g < N_GROUPS; g++) begin
            lz_run = bus.blank_lz[g];
            for (int p = GROUP_DIGITS - 1; p >= 0; p--) begin
                lz_run = lz_run && !disp_q[g*GROUP_DIGITS + p].dash
                                && (disp_q[g*GROUP_DIGITS + p].nib == 4'd0);
                blank_vec[g*GROUP_DIGITS + p] = lz_run && (p != 0);
            end
        end

        cur    = disp_q[scan_q];
        tube_d = blank_vec[scan_q] ? GLYPH_BLANK :
                 cur.dash          ? GLYPH_DASH  : nib_to_glyph(cur.nib);
        dp_d   = !bus.dp_mask[scan_q];
        en_d   = '1;
        if (!(bus.blink_mask[scan_q] && (blink_q >= BLK_W'(BLINK_FRAMES)))) en_d[scan_q] = 1'b0;
    end

    assign seg_tube      = tube_q;
    assign seg_dp        = dp_q;
    assign seg_enable    = en_q;
    assign bus.conv_busy = conv_busy_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - randomized self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;
    localparam int NG = 2;
    localparam int GD = 4;
    localparam int GW = 16;
    localparam int BF = 2;
    localparam int ND = NG * GD;
    localparam int SETTLE = 100;
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E };

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [6:0]    seg_tube;
    logic          seg_dp;
    logic [ND-1:0] seg_enable;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int m_val [NG];
    bit m_hex [NG];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.N_GROUPS(NG), .GROUP_DIGITS(GD), .GRP_W(GW)) bus ();

    seven_seg_scan_ctrl #(
        .N_GROUPS(NG), .GROUP_DIGITS(GD), .GRP_W(GW), .BLINK_FRAMES(BF)
    ) dut (
        .clk_tube   (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .seg_tube   (seg_tube),
        .seg_dp     (seg_dp),
        .seg_enable (seg_enable)
    );

    // Cycles since reset release; the digit on the pins at cycle k is (k-1) mod ND
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int pow10(input int e);
        int r = 1;
        repeat (e) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] exp_tube(input int d);
        int g = d / GD;
        int p = d % GD;
        int v = m_val[g];
        int hi;
        if (m_hex[g]) begin
            hi = v >> (4 * p);
            if (bus.blank_lz[g] && p != 0 && hi == 0) return 7'h7F;
            return GLYPHS[hi & 15];
        end
        if (v >= pow10(GD)) return 7'h3F;
        hi = v / pow10(p);
        if (bus.blank_lz[g] && p != 0 && hi == 0) return 7'h7F;
        return GLYPHS[hi % 10];
    endfunction

    function automatic logic [ND-1:0] exp_en(input int d, input int k);
        logic [ND-1:0] e = '1;
        int frame = (k - 1) / ND;
        if (!(bus.blink_mask[d] && (frame % (2 * BF)) >= BF)) e[d] = 1'b0;
        return e;
    endfunction

    function automatic logic [NG-1:0] exp_ovf();
        logic [NG-1:0] o = '0;
        for (int g = 0; g < NG; g++) o[g] = !m_hex[g] && (m_val[g] >= pow10(GD));
        return o;
    endfunction

    task automatic set_fields(input logic [15:0] v1, input logic [15:0] v0,
                              input logic [1:0] hx, input logic [1:0] blz);
        bus.value_bus = {v1, v0};
        bus.hex_mode  = hx;
        bus.blank_lz  = blz;
    endtask

    task automatic model_fields(input int v1, input int v0, input bit h1, input bit h0);
        m_val[1] = v1; m_val[0] = v0;
        m_hex[1] = h1; m_hex[0] = h0;
    endtask

    task automatic test_reset();
        int d;
        set_fields(16'd1234, 16'd56, 2'b00, 2'b11);
        bus.dp_mask = '0;
        bus.blink_mask = '0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (seg_enable !== '1 || seg_tube !== 7'h7F || seg_dp !== 1'b1 ||
            bus.conv_busy !== 1'b0 || bus.overflow !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: en=%b tube=%h dp=%b busy=%b ovf=%b, required en=11111111 tube=7f dp=1 busy=0 ovf=00",
                     seg_enable, seg_tube, seg_dp, bus.conv_busy, bus.overflow);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_fields(0, 0, 0, 0);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc) || seg_dp !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_display d%0d: tube=%h en=%b dp=%b, required tube=%h en=%b dp=1",
                         d, seg_tube, seg_enable, seg_dp, exp_tube(d), exp_en(d, cyc));
            end
        end
        repeat (2 * ND + SETTLE) @(negedge clk);
        model_fields(1234, 56, 0, 0);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc) || seg_dp !== 1'b1) begin
                n_bad++;
                $display("FAIL first_commit d%0d: tube=%h en=%b dp=%b, required tube=%h en=%b dp=1",
                         d, seg_tube, seg_enable, seg_dp, exp_tube(d), exp_en(d, cyc));
            end
        end
    endtask

    task automatic test_zero_blank();
        int d;
        set_fields(16'd0, 16'd0, 2'b00, 2'b01);
        repeat (SETTLE) @(negedge clk);
        model_fields(0, 0, 0, 0);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc)) begin
                n_bad++;
                $display("FAIL zero_blank d%0d: tube=%h en=%b, required tube=%h en=%b",
                         d, seg_tube, seg_enable, exp_tube(d), exp_en(d, cyc));
            end
        end
    endtask

    task automatic test_overflow();
        int d;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                set_fields(16'd10000, 16'd9999, 2'b00, 2'b00);
                model_fields(10000, 9999, 0, 0);
            end else begin
                set_fields(16'd9999, 16'd65535, 2'b00, 2'b11);
                model_fields(9999, 65535, 0, 0);
            end
            repeat (SETTLE) @(negedge clk);
            n_cmp++;
            if (bus.overflow !== exp_ovf()) begin
                n_bad++;
                $display("FAIL overflow_flag pass%0d: got %b, required %b", pass, bus.overflow, exp_ovf());
            end
            for (int i = 0; i < ND; i++) begin
                @(negedge clk);
                d = (cyc - 1) % ND;
                n_cmp++;
                if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc)) begin
                    n_bad++;
                    $display("FAIL overflow_digits pass%0d d%0d: tube=%h en=%b, required tube=%h en=%b",
                             pass, d, seg_tube, seg_enable, exp_tube(d), exp_en(d, cyc));
                end
            end
        end
    endtask

    task automatic test_hex();
        int d;
        logic [6:0] beef [4] = '{7'h0E, 7'h06, 7'h06, 7'h03};
        set_fields(16'hBEEF, 16'h00A5, 2'b11, 2'b01);
        bus.dp_mask = 8'b0010_0100;
        repeat (SETTLE) @(negedge clk);
        model_fields(32'hBEEF, 32'h00A5, 1, 1);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc) ||
                seg_dp !== !bus.dp_mask[d] || $countones(~seg_enable) != 1) begin
                n_bad++;
                $display("FAIL hex d%0d: tube=%h en=%b dp=%b, required tube=%h en=%b dp=%b",
                         d, seg_tube, seg_enable, seg_dp, exp_tube(d), exp_en(d, cyc), !bus.dp_mask[d]);
            end
            if (d >= GD) begin
                n_cmp++;
                if (seg_tube !== beef[d - GD]) begin
                    n_bad++;
                    $display("FAIL hex_beef d%0d: tube=%h, required %h", d, seg_tube, beef[d - GD]);
                end
            end
        end
        n_cmp++;
        if (bus.overflow !== 2'b00) begin
            n_bad++;
            $display("FAIL hex_overflow: got %b, required 00", bus.overflow);
        end
        bus.dp_mask = '0;
    endtask

    task automatic test_snapshot();
        int d;
        bit seen;
        set_fields(16'd4321, 16'd8765, 2'b00, 2'b00);
        repeat (SETTLE) @(negedge clk);
        seen = 0;
        for (int i = 0; i < SETTLE && !seen; i++) begin
            @(negedge clk);
            if (bus.conv_busy === 1'b0) seen = 1;
        end
        if (seen) begin
            seen = 0;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(negedge clk);
                if (bus.conv_busy === 1'b1) seen = 1;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL snapshot_start: conv_busy=%b, required a 0->1 transition within bound", bus.conv_busy);
        end
        // Both fields have been loaded 20 cycles after the pass starts
        repeat (20) @(negedge clk);
        bus.value_bus = {16'd1111, 16'd2222};
        seen = 0;
        for (int i = 0; i < SETTLE && !seen; i++) begin
            @(negedge clk);
            if (bus.conv_busy === 1'b0) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL snapshot_commit: conv_busy=%b, required 0 within bound", bus.conv_busy);
        end
        model_fields(4321, 8765, 0, 0);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d)) begin
                n_bad++;
                $display("FAIL snapshot_old d%0d: tube=%h, required %h", d, seg_tube, exp_tube(d));
            end
        end
        repeat (SETTLE) @(negedge clk);
        model_fields(1111, 2222, 0, 0);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d)) begin
                n_bad++;
                $display("FAIL snapshot_new d%0d: tube=%h, required %h", d, seg_tube, exp_tube(d));
            end
        end
    endtask

    task automatic test_random();
        int d;
        logic [15:0] v [NG];
        logic [1:0]  hx, blz;
        for (int it = 0; it < 6; it++) begin
            for (int g = 0; g < NG; g++) begin
                v[g] = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 2) == 0) v[g] = 16'($urandom_range(0, 120));
            end
            hx  = 2'($urandom_range(0, 3));
            blz = 2'($urandom_range(0, 3));
            set_fields(v[1], v[0], hx, blz);
            bus.dp_mask = 8'($urandom_range(0, 255));
            repeat (SETTLE) @(negedge clk);
            model_fields(int'(v[1]), int'(v[0]), hx[1], hx[0]);
            n_cmp++;
            if (bus.overflow !== exp_ovf()) begin
                n_bad++;
                $display("FAIL random_ovf it%0d: got %b, required %b", it, bus.overflow, exp_ovf());
            end
            for (int i = 0; i < ND; i++) begin
                @(negedge clk);
                d = (cyc - 1) % ND;
                n_cmp++;
                if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc) || seg_dp !== !bus.dp_mask[d]) begin
                    n_bad++;
                    $display("FAIL random it%0d d%0d: tube=%h en=%b dp=%b, required tube=%h en=%b dp=%b",
                             it, d, seg_tube, seg_enable, seg_dp, exp_tube(d), exp_en(d, cyc), !bus.dp_mask[d]);
                end
            end
        end
        bus.dp_mask = '0;
    endtask

    task automatic test_blink();
        int d;
        set_fields(16'd8888, 16'd8888, 2'b00, 2'b00);
        bus.blink_mask = 8'h01;
        repeat (SETTLE) @(negedge clk);
        model_fields(8888, 8888, 0, 0);
        for (int i = 0; i < 4 * BF * ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_enable !== exp_en(d, cyc) || seg_tube !== exp_tube(d)) begin
                n_bad++;
                $display("FAIL blink frame%0d d%0d: en=%b tube=%h, required en=%b tube=%h",
                         (cyc - 1) / ND, d, seg_enable, seg_tube, exp_en(d, cyc), exp_tube(d));
            end
        end
        bus.blink_mask = '0;
    endtask

    task automatic test_reset_mid_shift();
        int d;
        bit seen;
        set_fields(16'd10000, 16'd77, 2'b00, 2'b00);
        repeat (SETTLE) @(negedge clk);
        n_cmp++;
        if (bus.overflow !== 2'b10) begin
            n_bad++;
            $display("FAIL pre_reset_ovf: got %b, required 10", bus.overflow);
        end
        seen = 0;
        for (int i = 0; i < SETTLE && !seen; i++) begin
            @(negedge clk);
            if (bus.conv_busy === 1'b0) seen = 1;
        end
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!seen || seg_enable !== '1 || seg_tube !== 7'h7F || seg_dp !== 1'b1 ||
            bus.conv_busy !== 1'b0 || bus.overflow !== '0) begin
            n_bad++;
            $display("FAIL mid_shift_reset: idle_seen=%0d en=%b tube=%h dp=%b busy=%b ovf=%b, required idle_seen=1 en=11111111 tube=7f dp=1 busy=0 ovf=00",
                     seen, seg_enable, seg_tube, seg_dp, bus.conv_busy, bus.overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_fields(0, 0, 0, 0);
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            d = (cyc - 1) % ND;
            n_cmp++;
            if (seg_tube !== exp_tube(d) || seg_enable !== exp_en(d, cyc)) begin
                n_bad++;
                $display("FAIL post_reset_display d%0d: tube=%h en=%b, required tube=%h en=%b",
                         d, seg_tube, seg_enable, exp_tube(d), exp_en(d, cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_blank();
        test_overflow();
        test_hex();
        test_snapshot();
        test_random();
        test_blink();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
